// File: rtl/pipe_shifter_if.sv
// rtl/pipe_shifter_if.sv - operation/result handshake bundle for pipe_shifter
interface pipe_shifter_if #(
    parameter int WIDTH = 16
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [SHW-1:0]   in_amt;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;

    // Shifter side: consumes operations, produces results
    modport slave (
        input  in_valid, in_a, in_amt, in_op, out_ready,
        output in_ready, out_valid, out_res
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_a, in_amt, in_op, out_ready,
        input  in_ready, out_valid, out_res
    );
endinterface

// File: rtl/pipe_shifter.sv
// rtl/pipe_shifter.sv - two-stage SLL/ROR/SRL/SRA shifter; PIPE_SHIFTER_ROT_EN enables ROR on op 01
module pipe_shifter #(
    parameter int WIDTH = 16
) (
    input logic           clk,
    input logic           rst_n,
    pipe_shifter_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int LO  = SHW / 2;
    localparam int HI  = SHW - LO;

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic [1:0]       s1_op_q, s1_op_d;
    logic [HI-1:0]    s1_amt_hi_q, s1_amt_hi_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_res_q, out_res_d;
    logic             s2_adv;
    logic             in_ready;

    // One partial shift; both stages reuse it with their share of the amount.
    // SRA keeps the sign correct in stage 2 because a partial arithmetic
    // shift leaves the original sign bit in the MSB.
    function automatic logic [WIDTH-1:0] shift_op(input logic [WIDTH-1:0] a,
                                                  input logic [SHW-1:0]   amt,
                                                  input logic [1:0]       op);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = a << amt;
`ifdef PIPE_SHIFTER_ROT_EN
            2'b01:   r = WIDTH'({a, a} >> amt);
`else
            2'b01:   r = a << amt;
`endif
            2'b10:   r = a >> amt;
            default: r = $unsigned($signed(a) >>> amt);
        endcase
        return r;
    endfunction

    // Handshake: stage 2 moves when empty or drained, stage 1 when it can pass on
    always_comb begin
        s2_adv   = !out_valid_q | bus.out_ready;
        in_ready = !s1_valid_q | s2_adv;
    end

    // Stage 1 next state: low amount bits applied, high bits carried forward
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        s1_op_d     = s1_op_q;
        s1_amt_hi_d = s1_amt_hi_q;
        if (in_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_data_d   = shift_op(bus.in_a, {{HI{1'b0}}, bus.in_amt[LO-1:0]}, bus.in_op);
                s1_op_d     = bus.in_op;
                s1_amt_hi_d = bus.in_amt[SHW-1:LO];
            end
        end
    end

    // Stage 2 next state: remaining amount bits applied; held while stalled
    always_comb begin
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_res_d = shift_op(s1_data_q, {s1_amt_hi_q, {LO{1'b0}}}, s1_op_q);
            end
        end
    end

    // Pipeline registers; reset drops every in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_op_q     <= '0;
            s1_amt_hi_q <= '0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_op_q     <= s1_op_d;
            s1_amt_hi_q <= s1_amt_hi_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_res   = out_res_q;
endmodule

// File: tb/tb_pipe_shifter.sv
// tb/tb_pipe_shifter.sv - self-checking bench for pipe_shifter (vectors, corner sequences, random stream)
module tb_pipe_shifter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    pipe_shifter_if #(.WIDTH(16)) bus ();

    pipe_shifter #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [3:0]  amt;
        logic [1:0]  op;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: shifts as multiplication/division by powers of two
    function automatic logic [15:0] model(input logic [15:0] a, input int amt, input logic [1:0] op);
        longint m  = 65536;
        longint p  = longint'(1) << amt;
        longint ua = longint'(a);
        longint sv;
        longint r;
        case (op)
            2'b00: r = (ua * p) % m;
`ifdef PIPE_SHIFTER_ROT_EN
            2'b01: r = ua / p + (ua % p) * (m / p);
`else
            2'b01: r = (ua * p) % m;
`endif
            2'b10: r = ua / p;
            default: begin
                sv = a[15] ? ua - m : ua;
                if (sv < 0) r = -((-sv + p - 1) / p);
                else        r = sv / p;
                if (r < 0) r = r + m;
            end
        endcase
        return 16'(r);
    endfunction

    task automatic drive(input logic v, input logic [15:0] a, input logic [3:0] amt, input logic [1:0] op);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_amt   = amt;
        bus.in_op    = op;
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 16'h0, 4'h0, 2'b00);

        // Reset state
        #1;
        check("reset_out_valid", 16'(bus.out_valid), 16'h0);
        check("reset_out_res", bus.out_res, 16'h0);
        check("reset_in_ready", 16'(bus.in_ready), 16'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{"sll_15",   16'h0001, 4'd15, 2'b00, 16'h8000});
        vecs.push_back('{"sll_0",    16'h0001, 4'd0,  2'b00, 16'h0001});
        vecs.push_back('{"sra_15",   16'h8000, 4'd15, 2'b11, 16'hFFFF});
        vecs.push_back('{"srl_15",   16'h8000, 4'd15, 2'b10, 16'h0001});
        vecs.push_back('{"sra_4",    16'hF0F0, 4'd4,  2'b11, 16'hFF0F});
        vecs.push_back('{"srl_4",    16'hF0F0, 4'd4,  2'b10, 16'h0F0F});
        vecs.push_back('{"sll_5",    16'h00FF, 4'd5,  2'b00, 16'h1FE0});
        vecs.push_back('{"sra_pos3", 16'h7FFF, 4'd3,  2'b11, 16'h0FFF});
        vecs.push_back('{"srl_0",    16'hA5C3, 4'd0,  2'b10, 16'hA5C3});
        vecs.push_back('{"sra_0",    16'hA5C3, 4'd0,  2'b11, 16'hA5C3});
        vecs.push_back('{"op01_0",   16'hA5C3, 4'd0,  2'b01, 16'hA5C3});
`ifdef PIPE_SHIFTER_ROT_EN
        vecs.push_back('{"ror_1",    16'h0001, 4'd1,  2'b01, 16'h8000});
        vecs.push_back('{"ror_8",    16'h1234, 4'd8,  2'b01, 16'h3412});
        vecs.push_back('{"ror_5",    16'h000F, 4'd5,  2'b01, 16'h7800});
`else
        vecs.push_back('{"op01_1",   16'h0001, 4'd1,  2'b01, 16'h0002});
        vecs.push_back('{"op01_8",   16'h1234, 4'd8,  2'b01, 16'h3400});
        vecs.push_back('{"op01_5",   16'h000F, 4'd5,  2'b01, 16'h01E0});
`endif

        // Directed vectors with exact latency: presented in cycle N, visible after edge N+2
        foreach (vecs[i]) begin
            v = vecs[i];
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            drive(1'b1, v.a, v.amt, v.op);
            @(negedge clk);
            check({v.name, "_in_ready"}, 16'(bus.in_ready), 16'h1);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            @(negedge clk);
            check({v.name, "_early"}, 16'(bus.out_valid), 16'h0);
            @(negedge clk);
            check({v.name, "_valid"}, 16'(bus.out_valid), 16'h1);
            check({v.name, "_res"}, bus.out_res, v.exp);
        end
        @(negedge clk);

        // Backpressure: three back-to-back ops with consumer stalled
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h0001, 4'd4, 2'b00);
        @(negedge clk);
        check("stall_rdy_a", 16'(bus.in_ready), 16'h1);
        @(posedge clk); #1;
        drive(1'b1, 16'h8000, 4'd1, 2'b11);
        @(negedge clk);
        check("stall_rdy_b", 16'(bus.in_ready), 16'h1);
        @(posedge clk); #1;
        drive(1'b1, 16'h00F0, 4'd4, 2'b10);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_rdy_c", 16'(bus.in_ready), 16'h0);
            check("stall_valid", 16'(bus.out_valid), 16'h1);
            check("stall_hold", bus.out_res, 16'h0010);
            if (k < 2) @(posedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("drain_rdy", 16'(bus.in_ready), 16'h1);
        check("drain_a_valid", 16'(bus.out_valid), 16'h1);
        check("drain_a", bus.out_res, 16'h0010);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("drain_b_valid", 16'(bus.out_valid), 16'h1);
        check("drain_b", bus.out_res, 16'hC000);
        @(negedge clk);
        check("drain_c_valid", 16'(bus.out_valid), 16'h1);
        check("drain_c", bus.out_res, 16'h000F);
        @(negedge clk);
        check("drain_empty", 16'(bus.out_valid), 16'h0);

        // Reset with both stages full: asynchronous clear, nothing stale afterwards
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h1111, 4'd1, 2'b00);
        @(posedge clk); #1;
        drive(1'b1, 16'h2222, 4'd1, 2'b00);
        @(posedge clk); #1;
        drive(1'b1, 16'h3333, 4'd1, 2'b00);
        @(negedge clk);
        check("full_rdy", 16'(bus.in_ready), 16'h0);
        check("full_valid", 16'(bus.out_valid), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 16'(bus.out_valid), 16'h0);
        check("arst_res", bus.out_res, 16'h0);
        check("arst_rdy", 16'(bus.in_ready), 16'h1);
        @(negedge clk);
        check("arst_hold_valid", 16'(bus.out_valid), 16'h0);
        check("arst_hold_res", bus.out_res, 16'h0);
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 16'h0001, 4'd15, 2'b00);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_no_stale", 16'(bus.out_valid), 16'h0);
        @(negedge clk);
        check("post_rst_valid", 16'(bus.out_valid), 16'h1);
        check("post_rst_res", bus.out_res, 16'h8000);
        @(negedge clk);
        check("post_rst_empty", 16'(bus.out_valid), 16'h0);

        // Random stream with random stalls against the reference model
        begin
            logic [15:0] q[$];
            int          accepted;
            logic        prev_stall;
            logic [15:0] prev_res;
            accepted   = 0;
            prev_stall = 1'b0;
            prev_res   = 16'h0;
            for (int cyc = 0; cyc < 60000 && (accepted < 10000 || q.size() != 0); cyc++) begin
                @(posedge clk); #1;
                if (accepted < 10000)
                    drive($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom), 2'($urandom));
                else
                    bus.in_valid = 1'b0;
                bus.out_ready = ($urandom_range(0, 9) < 7);
                @(negedge clk);
                if (prev_stall) begin
                    check("rand_hold_valid", 16'(bus.out_valid), 16'h1);
                    check("rand_hold_res", bus.out_res, prev_res);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) check("rand_spurious", 16'(bus.out_valid), 16'h0);
                    else               check("rand_res", bus.out_res, q.pop_front());
                end
                if (bus.in_valid && bus.in_ready) begin
                    q.push_back(model(bus.in_a, int'(bus.in_amt), bus.in_op));
                    accepted++;
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_res   = bus.out_res;
            end
            check("rand_accepted", 16'(accepted >= 10000), 16'h1);
            check("rand_drained", 16'(q.size()), 16'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
